// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-attached RAM controller: command opcodes and
// the pointer wrap rule used by burst addressing.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_e;

    // Post-increment with wrap from depth-1 back to 0; depth need not be 2^n.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM with registered read data. A simultaneous write
// and read returns the write data (write-first); read data holds between reads.
module spi_ram_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // The array itself is never reset; only the output register is.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= we ? wdata : mem[addr];
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder for the SPI RAM: address/data opcodes, independent write and
// read pointers with optional burst increment, and one-cycle tx_valid/cmd_err pulses.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH+1:0] din,
    input  logic                  burst_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  tx_valid,
    output logic                  cmd_err
);

    if (ADDR_WIDTH > DATA_WIDTH) begin : g_bad_addr_width
        $error("spi_ram_ctrl: ADDR_WIDTH exceeds DATA_WIDTH");
    end

    cmd_e                  op;
    logic [DATA_WIDTH-1:0] payload;
    logic                  in_range;

    logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_nxt;
    logic [ADDR_WIDTH-1:0] rd_ptr, rd_ptr_nxt;
    logic                  rd_armed, rd_armed_nxt;
    logic                  tx_nxt, err_nxt;

    logic                  mem_we, mem_re;
    logic [ADDR_WIDTH-1:0] mem_addr;

    assign op      = cmd_e'(din[DATA_WIDTH+1:DATA_WIDTH]);
    assign payload = din[DATA_WIDTH-1:0];
    // One extra bit so DEPTH == 2^DATA_WIDTH still compares correctly.
    assign in_range = {1'b0, payload} < (DATA_WIDTH + 1)'(DEPTH);

    function automatic logic [ADDR_WIDTH-1:0] bump(input logic [ADDR_WIDTH-1:0] p);
        return ADDR_WIDTH'(next_ptr(32'(p), DEPTH));
    endfunction

    always_comb begin
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        rd_armed_nxt = rd_armed;
        tx_nxt       = 1'b0;
        err_nxt      = 1'b0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_addr     = rd_ptr;
        if (rx_valid) begin
            unique case (op)
                WR_ADDR: begin
                    if (in_range) wr_ptr_nxt = payload[ADDR_WIDTH-1:0];
                    else          err_nxt    = 1'b1;
                end
                WR_DATA: begin
                    mem_we   = 1'b1;
                    mem_addr = wr_ptr;
                    if (burst_en) wr_ptr_nxt = bump(wr_ptr);
                end
                RD_ADDR: begin
                    if (in_range) begin
                        rd_ptr_nxt   = payload[ADDR_WIDTH-1:0];
                        rd_armed_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                RD_DATA: begin
                    // Reading before any valid RD_ADDR is an error and leaves dout alone.
                    if (rd_armed) begin
                        mem_re = 1'b1;
                        tx_nxt = 1'b1;
                        if (burst_en) rd_ptr_nxt = bump(rd_ptr);
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_armed <= 1'b0;
            tx_valid <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            rd_armed <= rd_armed_nxt;
            tx_valid <= tx_nxt;
            cmd_err  <= err_nxt;
        end
    end

    // The memory's registered read port is the dout register.
    spi_ram_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we),
        .re   (mem_re),
        .addr (mem_addr),
        .wdata(payload),
        .rdata(dout)
    );

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Three controller configurations driven by directed and random commands and
// checked each cycle against a word-level model of the command rules.
module tb_spi_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rx_valid, burst_en, tx_valid, cmd_err;
    logic [9:0]  din0, din1;
    logic [17:0] din2;
    logic [7:0]  dout0, dout1;
    logic [15:0] dout2;

    int ncmp = 0;
    int nerr = 0;

    int depth_a [3] = '{256, 200, 1024};
    int width_a [3] = '{8, 8, 16};

    // Reference model state
    int mem_m   [3][1024];
    bit known_m [3][1024];
    int wp [3], rp [3];
    bit armed [3];
    int edout [3];
    bit edk [3];
    bit etx [3], eerr [3];

    always #5 clk = ~clk;

    spi_ram_ctrl #(.DATA_WIDTH(8), .DEPTH(256)) u0 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid[0]), .din(din0), .burst_en(burst_en[0]),
        .dout(dout0), .tx_valid(tx_valid[0]), .cmd_err(cmd_err[0]));
    spi_ram_ctrl #(.DATA_WIDTH(8), .DEPTH(200)) u1 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid[1]), .din(din1), .burst_en(burst_en[1]),
        .dout(dout1), .tx_valid(tx_valid[1]), .cmd_err(cmd_err[1]));
    spi_ram_ctrl #(.DATA_WIDTH(16), .DEPTH(1024)) u2 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid[2]), .din(din2), .burst_en(burst_en[2]),
        .dout(dout2), .tx_valid(tx_valid[2]), .cmd_err(cmd_err[2]));

    function automatic int mask_of(int u);
        return (1 << width_a[u]) - 1;
    endfunction

    function automatic logic [31:0] get_dout(int u);
        case (u)
            0:       return 32'(dout0);
            1:       return 32'(dout1);
            default: return 32'(dout2);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("u%0d tx_valid", k), 32'(tx_valid[k]), 32'(etx[k]));
            check($sformatf("u%0d cmd_err", k), 32'(cmd_err[k]), 32'(eerr[k]));
            if (edk[k]) check($sformatf("u%0d dout", k), get_dout(k), edout[k]);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            wp[k] = 0; rp[k] = 0; armed[k] = 0;
            edout[k] = 0; edk[k] = 1; etx[k] = 0; eerr[k] = 0;
        end
    endtask

    function automatic int wrap_inc(int p, int depth);
        return (p + 1) % depth;
    endfunction

    task automatic model_cmd(int u, int op, int pay, bit b);
        case (op)
            0: if (pay < depth_a[u]) wp[u] = pay; else eerr[u] = 1;
            1: begin
                mem_m[u][wp[u]] = pay;
                known_m[u][wp[u]] = 1;
                if (b) wp[u] = wrap_inc(wp[u], depth_a[u]);
            end
            2: if (pay < depth_a[u]) begin rp[u] = pay; armed[u] = 1; end
               else eerr[u] = 1;
            default: if (armed[u]) begin
                edout[u] = mem_m[u][rp[u]];
                edk[u]   = known_m[u][rp[u]];
                etx[u]   = 1;
                if (b) rp[u] = wrap_inc(rp[u], depth_a[u]);
            end else eerr[u] = 1;
        endcase
    endtask

    // One clock cycle: unit u gets a command when v=1, other units see junk with rx_valid=0.
    task automatic step(int u, bit v, int op, int pay_raw, bit b);
        logic [1:0] opv;
        int pay;
        opv = op[1:0];
        pay = pay_raw & mask_of(u);
        @(negedge clk);
        rx_valid = '0;
        burst_en = 3'($urandom);
        din0 = 10'($urandom);
        din1 = 10'($urandom);
        din2 = 18'($urandom);
        if (v) begin
            rx_valid[u] = 1'b1;
            burst_en[u] = b;
            case (u)
                0:       din0 = {opv, pay[7:0]};
                1:       din1 = {opv, pay[7:0]};
                default: din2 = {opv, pay[15:0]};
            endcase
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin etx[k] = 0; eerr[k] = 0; end
        if (v) model_cmd(u, op, pay, b);
        #1;
        check_all();
    endtask

    // Reset asserted mid-cycle, checked before the next edge, released on the negedge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rx_valid = '0;
        rst = 1'b0;
    endtask

    initial begin
        int u, op, pay;
        bit v, b;
        rst = 1'b1;
        rx_valid = '0; burst_en = '0; din0 = '0; din1 = '0; din2 = '0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Basic write then read
        step(0, 1, 0, 'h10, 0);
        step(0, 1, 1, 'hA5, 0);
        step(0, 1, 2, 'h10, 0);
        step(0, 1, 3, 0, 0);
        check("dir rd A5", get_dout(0), 32'hA5);
        step(0, 0, 0, 0, 0);
        check("dir hold A5", get_dout(0), 32'hA5);

        // Write-first: read in the cycle after the write
        step(0, 1, 2, 'h30, 0);
        step(0, 1, 0, 'h30, 0);
        step(0, 1, 1, 'h77, 0);
        step(0, 1, 3, 0, 0);
        check("dir write-first", get_dout(0), 32'h77);

        // Burst write/read across the FF->00 wrap
        step(0, 1, 0, 'hFE, 1);
        step(0, 1, 1, 'h11, 1);
        step(0, 1, 1, 'h22, 1);
        step(0, 1, 1, 'h33, 1);
        step(0, 1, 2, 'hFE, 1);
        step(0, 1, 3, 0, 1);
        check("burst 1", get_dout(0), 32'h11);
        step(0, 1, 3, 0, 1);
        check("burst 2", get_dout(0), 32'h22);
        step(0, 1, 3, 0, 1);
        check("burst 3 wrap", get_dout(0), 32'h33);

        // Async reset between burst reads, then unarmed read errors
        step(0, 1, 2, 'h10, 1);
        step(0, 1, 3, 0, 1);
        async_reset();
        check("rst dout", get_dout(0), 32'h0);
        step(0, 1, 3, 0, 1);
        check("unarmed err", 32'(cmd_err[0]), 32'h1);

        // DEPTH=200: out-of-range address rejected, pointer kept
        step(1, 1, 0, 'h20, 0);
        step(1, 1, 0, 'hC8, 0);
        step(1, 1, 1, 'h5A, 0);
        step(1, 1, 2, 'h20, 0);
        step(1, 1, 3, 0, 0);
        check("d200 keep ptr", get_dout(1), 32'h5A);
        step(1, 1, 2, 'hC8, 0);
        step(1, 1, 3, 0, 0);
        step(1, 1, 0, 199, 1);
        step(1, 1, 1, 'h66, 1);
        step(1, 1, 1, 'h67, 1);
        step(1, 1, 2, 199, 1);
        step(1, 1, 3, 0, 1);
        step(1, 1, 3, 0, 1);
        check("d200 wrap", get_dout(1), 32'h67);

        // 16-bit / 1024-deep
        step(2, 1, 0, 'h3FF, 0);
        step(2, 1, 1, 'hBEEF, 0);
        step(2, 1, 2, 'h3FF, 0);
        step(2, 1, 3, 0, 0);
        check("w16 BEEF", get_dout(2), 32'hBEEF);
        step(2, 1, 0, 'h400, 0);
        step(2, 1, 2, 'hFFFF, 0);

        // Random traffic with addresses clustered near 0 and near DEPTH
        for (int i = 0; i < 900; i++) begin
            u   = $urandom_range(0, 2);
            v   = ($urandom_range(0, 5) != 0);
            op  = $urandom_range(0, 3);
            b   = 1'($urandom_range(0, 1));
            if (op == 1)
                pay = $urandom;
            else if ($urandom_range(0, 3) == 0)
                pay = depth_a[u] - 4 + $urandom_range(0, 7);
            else
                pay = $urandom_range(0, 15);
            step(u, v, op, pay, b);
            check("tx/err exclusive", 32'(tx_valid & cmd_err), 32'h0);
            if (i % 300 == 150) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- Parametrised successor to the SPI-slave 8-bit/256-word RAM, with configurable data width and depth.
- Receives DATA_WIDTH+2-bit command words from the SPI slave front end; din[MSB:MSB-1] is the opcode.
- Adds burst (auto-increment) addressing, out-of-range address detection and a read-without-address error flag.
- Returns read data to the SPI slave on dout, qualified by a single-cycle tx_valid.

Parameters:
- DATA_WIDTH, 8, width of stored word and of the dout payload.
- DEPTH, 256, number of words; need not be a power of two.
- ADDR_WIDTH, $clog2(DEPTH), address bits taken from din[ADDR_WIDTH-1:0]; must be <= DATA_WIDTH (elaboration-time assertion).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- rx_valid  input  1  din holds a valid command this cycle.
- din  input  DATA_WIDTH+2  bits [DATA_WIDTH+1:DATA_WIDTH] are the opcode; bits [DATA_WIDTH-1:0] are the payload.
- burst_en  input  1  sampled with each data command; 1 = post-increment the relevant pointer.
- dout  output  DATA_WIDTH  read data, registered.
- tx_valid  output  1  dout is valid; one-cycle pulse.
- cmd_err  output  1  one-cycle pulse on an illegal command.

Behaviour:
- Reset (async assert, sync release):
  - dout=0, tx_valid=0, cmd_err=0.
  - wr_ptr=0, rd_ptr=0, rd_armed=0.
  - Memory contents are not cleared.
- Opcodes (acted on only when rx_valid=1; rx_valid=0 means no state change):
  - 00 WR_ADDR: if payload < DEPTH, wr_ptr<=payload; else cmd_err=1 next cycle and wr_ptr is unchanged.
  - 01 WR_DATA: mem[wr_ptr]<=payload[DATA_WIDTH-1:0]. If burst_en, wr_ptr<=(wr_ptr==DEPTH-1)?0:wr_ptr+1.
  - 10 RD_ADDR: if payload < DEPTH, rd_ptr<=payload and rd_armed<=1; else cmd_err=1 next cycle, and rd_ptr/rd_armed are unchanged.
  - 11 RD_DATA:
    - If rd_armed: dout<=mem[rd_ptr] and tx_valid=1 in the next cycle only. If burst_en, rd_ptr post-increments with the same wrap rule; rd_armed stays 1.
    - If not rd_armed: cmd_err=1 next cycle, tx_valid stays 0, dout holds.
- Latency: RD_DATA in cycle N gives tx_valid=1 and dout valid in cycle N+1; tx_valid=0 in N+2 unless another RD_DATA arrived in N+1.
- dout holds its last value when tx_valid=0.
- tx_valid and cmd_err are never both 1 in the same cycle.
- Ordering:
  - WR_DATA in cycle N followed by RD_DATA of the same address in N+1 returns the new data (write-first).
  - A WR_ADDR or WR_DATA never alters rd_ptr, and read commands never alter wr_ptr.
- Wrap: burst from DEPTH-1 goes to 0 with no error.
- Non-power-of-two DEPTH: addresses DEPTH..2^ADDR_WIDTH-1 are rejected as out of range.
- Reset mid-burst: pointers return to 0 and rd_armed clears. The first RD_DATA after reset errors until a valid RD_ADDR is received.
- Back-to-back commands every cycle are supported with no stall; there is no ready/backpressure output.

Decomposition:
- Package spi_ram_pkg:
  - Opcode enum cmd_e {WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11}.
  - Function next_ptr(ptr, depth) implementing the wrap rule.
- Sub-module spi_ram_mem: single-port synchronous array with write enable, write-first read and registered read output; parametrised by DATA_WIDTH/DEPTH.
- spi_ram_ctrl holds the command decode, pointers, rd_armed and the output flags.

Test Plan:
- WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA -> tx_valid high for exactly one cycle with dout=0xA5; tx_valid low after WR_ADDR, WR_DATA and RD_ADDR.
- burst_en=1: WR_ADDR 0xFE, WR_DATA 0x11, 0x22, 0x33; then RD_ADDR 0xFE and 3x RD_DATA -> dout sequence 0x11, 0x22, 0x33, showing wrap of address 0xFF to 0x00.
- After reset, RD_DATA with no RD_ADDR -> cmd_err pulses for one cycle, tx_valid=0, dout=0.
- DEPTH=200: WR_ADDR 0xC8 -> cmd_err=1 and wr_ptr unchanged; WR_DATA 0x5A then lands at the previous address (check with a readback).
- rst asserted between two burst RD_DATA commands -> dout=0 and tx_valid=0 immediately (async); the next RD_DATA raises cmd_err.
- DATA_WIDTH=16, DEPTH=1024: WR_ADDR 0x3FF, WR_DATA 0xBEEF, RD_ADDR 0x3FF, RD_DATA -> dout=0xBEEF.
